// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO front end: LED mode codes and width helper.
package gpio_pkg;

  typedef logic [1:0] led_mode_t;

  localparam led_mode_t LED_MODE_OFF    = 2'b00;
  localparam led_mode_t LED_MODE_ON     = 2'b01;
  localparam led_mode_t LED_MODE_FOLLOW = 2'b10;
  localparam led_mode_t LED_MODE_BLINK  = 2'b11;

  // Bits needed to hold 0..n-1, never less than one so ports and counters stay legal.
  function automatic int unsigned min_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: two-flop synchroniser, stability counter, debounced level and edge pulses.
module switch_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic state,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = min_width(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] cnt;

  // Bring the raw asynchronous pin into the clock domain before anything looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= pin;
      sync1 <= sync0;
    end
  end

  // Accept a new level only after it has disagreed with the current one for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else if (sync1 == state) begin
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      state <= sync1;
      rise  <= sync1;
      fall  <= ~sync1;
    end else begin
      cnt  <= cnt + 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

endmodule

// File: rtl/gpio_io_ctrl.sv
// Board I/O front end: debounced switches with edge pulses and sticky IRQ, per-LED mode control.
module gpio_io_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned N_SW            = 4,
  parameter int unsigned N_LED           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLINK_DIV       = 25000000,
  localparam int unsigned IDX_W          = min_width(N_LED)
) (
  input  logic             SYSTEMCLOCK,
  input  logic             PUSH_BUTTON_RESET_RAW,
  input  logic [N_SW-1:0]  gpio_switch,
  output logic [N_LED-1:0] gpio_led,
  input  logic             led_mode_wr,
  input  logic [IDX_W-1:0] led_mode_idx,
  input  logic [1:0]       led_mode_data,
  output logic [N_SW-1:0]  sw_state,
  output logic [N_SW-1:0]  sw_rise,
  output logic [N_SW-1:0]  sw_fall,
  output logic             sw_irq,
  input  logic             sw_irq_clear
);

  localparam int unsigned PW = min_width(BLINK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(BLINK_DIV - 1);

  led_mode_t [N_LED-1:0] mode;
  logic [PW-1:0]         presc;
  logic                  blink_phase;

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (SYSTEMCLOCK),
      .rst_n(PUSH_BUTTON_RESET_RAW),
      .pin  (gpio_switch[g]),
      .state(sw_state[g]),
      .rise (sw_rise[g]),
      .fall (sw_fall[g])
    );
  end

  // Mode registers; an index with no matching LED simply matches no register and is dropped.
  always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
    if (!PUSH_BUTTON_RESET_RAW) begin
      mode <= '{default: LED_MODE_OFF};
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        if (led_mode_wr && (led_mode_idx == IDX_W'(i))) begin
          mode[i] <= led_mode_data;
        end
      end
    end
  end

  // Free-running blink prescaler; all blinking LEDs share this one phase.
  always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
    if (!PUSH_BUTTON_RESET_RAW) begin
      presc       <= '0;
      blink_phase <= 1'b0;
    end else if (presc == PRESC_MAX) begin
      presc       <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Registered LED mux selecting each LED's source from its mode.
  always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
    if (!PUSH_BUTTON_RESET_RAW) begin
      gpio_led <= '0;
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        case (mode[i])
          LED_MODE_OFF:    gpio_led[i] <= 1'b0;
          LED_MODE_ON:     gpio_led[i] <= 1'b1;
          LED_MODE_FOLLOW: gpio_led[i] <= sw_state[i % N_SW];
          default:         gpio_led[i] <= blink_phase;
        endcase
      end
    end
  end

  // Sticky change flag; a new edge in the clearing cycle keeps it set so no event is lost.
  always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
    if (!PUSH_BUTTON_RESET_RAW) begin
      sw_irq <= 1'b0;
    end else if (|{sw_rise, sw_fall}) begin
      sw_irq <= 1'b1;
    end else if (sw_irq_clear) begin
      sw_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpio_io_ctrl.sv
// Directed bench for gpio_io_ctrl: reset, glitch rejection, LED modes, index range, IRQ race, async reset.
module tb_gpio_io_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] gpio_switch = 4'h0;
  logic [3:0] gpio_led;
  logic       led_mode_wr = 1'b0;
  logic [1:0] led_mode_idx = 2'd0;
  logic [1:0] led_mode_data = 2'd0;
  logic [3:0] sw_state;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       sw_irq;
  logic       sw_irq_clear = 1'b0;

  logic       wr2 = 1'b0;
  logic [1:0] idx2 = 2'd0;
  logic [1:0] data2 = 2'd0;
  logic [2:0] led2;
  logic [3:0] state2;
  logic [3:0] rise2;
  logic [3:0] fall2;
  logic       irq2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  gpio_io_ctrl #(
    .N_SW(4), .N_LED(4), .DEBOUNCE_CYCLES(8), .BLINK_DIV(4)
  ) dut (
    .SYSTEMCLOCK          (clk),
    .PUSH_BUTTON_RESET_RAW(rst_n),
    .gpio_switch          (gpio_switch),
    .gpio_led             (gpio_led),
    .led_mode_wr          (led_mode_wr),
    .led_mode_idx         (led_mode_idx),
    .led_mode_data        (led_mode_data),
    .sw_state             (sw_state),
    .sw_rise              (sw_rise),
    .sw_fall              (sw_fall),
    .sw_irq               (sw_irq),
    .sw_irq_clear         (sw_irq_clear)
  );

  gpio_io_ctrl #(
    .N_SW(4), .N_LED(3), .DEBOUNCE_CYCLES(8), .BLINK_DIV(4)
  ) dut3 (
    .SYSTEMCLOCK          (clk),
    .PUSH_BUTTON_RESET_RAW(rst_n),
    .gpio_switch          (4'h0),
    .gpio_led             (led2),
    .led_mode_wr          (wr2),
    .led_mode_idx         (idx2),
    .led_mode_data        (data2),
    .sw_state             (state2),
    .sw_rise              (rise2),
    .sw_fall              (fall2),
    .sw_irq               (irq2),
    .sw_irq_clear         (1'b0)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_irq();
    sw_irq_clear = 1'b1;
    step(1);
    sw_irq_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic s [16];
    int   t;
    int   highs;
    int   bad;
    int   rises;
    int   falls;
    int   rise_at;
    int   n;
    bit   found;

    // ---- 1: reset with switches held high ----
    #2 rst_n = 1'b0;
    gpio_switch = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_output("rst_led", 32'(gpio_led), 0);
      check_output("rst_state", 32'(sw_state), 0);
      check_output("rst_edges", 32'({sw_rise, sw_fall}), 0);
      check_output("rst_irq", 32'(sw_irq), 0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      check_output("qual_wait_state", 32'(sw_state), 0);
      check_output("qual_wait_rise", 32'(sw_rise), 0);
    end
    step(1);
    check_output("qual_state", 32'(sw_state), 32'hF);
    check_output("qual_rise", 32'(sw_rise), 32'hF);
    check_output("qual_fall", 32'(sw_fall), 0);
    step(1);
    check_output("qual_rise_end", 32'(sw_rise), 0);
    check_output("qual_irq", 32'(sw_irq), 1);

    // ---- 2: glitch on sw[0] ----
    gpio_switch = 4'hE;
    step(10);
    check_output("pre_fall_state", 32'(sw_state), 32'hE);
    check_output("pre_fall_pulse", 32'(sw_fall), 32'h1);
    step(1);
    clear_irq();
    check_output("irq_cleared", 32'(sw_irq), 0);
    gpio_switch = 4'hF;
    step(5);
    gpio_switch = 4'hE;
    step(3);
    gpio_switch = 4'hF;
    rises = 0;
    falls = 0;
    rise_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (sw_rise[0]) begin
        rises++;
        rise_at = i;
      end
      if (sw_fall[0]) falls++;
    end
    check_output("glitch_rise_count", 32'(rises), 1);
    check_output("glitch_rise_time", 32'(rise_at), 10);
    check_output("glitch_fall_count", 32'(falls), 0);
    check_output("glitch_state", 32'(sw_state), 32'hF);
    clear_irq();

    // ---- 3: LED modes ----
    led_mode_wr = 1'b1;
    led_mode_idx = 2'd0; led_mode_data = 2'b01; step(1);
    led_mode_idx = 2'd1; led_mode_data = 2'b10; step(1);
    led_mode_idx = 2'd2; led_mode_data = 2'b11; step(1);
    led_mode_idx = 2'd3; led_mode_data = 2'b00; step(1);
    led_mode_wr = 1'b0;
    check_output("led0_on", 32'(gpio_led[0]), 1);
    check_output("led1_follow_hi", 32'(gpio_led[1]), 1);
    check_output("led3_off", 32'(gpio_led[3]), 0);
    for (int i = 0; i < 16; i++) begin
      s[i] = gpio_led[2];
      step(1);
    end
    highs = 0;
    for (int i = 0; i < 16; i++) if (s[i]) highs++;
    check_output("blink_duty", 32'(highs), 8);
    t = 0;
    for (int i = 4; i >= 1; i--) if (s[i] != s[i-1]) t = i;
    check_output("blink_toggle_found", 32'(t != 0), 1);
    bad = 0;
    if (t != 0) begin
      for (int k = 0; k < 12; k++) begin
        if (s[t+k] != (s[t] ^ ((k / 4) % 2 == 1))) bad++;
      end
    end
    check_output("blink_period", 32'(bad), 0);

    gpio_switch = 4'hD;
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      step(1);
      n++;
      if (sw_state[1] == 1'b0) found = 1'b1;
    end
    check_output("follow_found", 32'(found), 1);
    check_output("follow_latency", 32'(n), 10);
    check_output("follow_fall1", 32'(sw_fall), 32'h2);
    check_output("follow_led_lag", 32'(gpio_led[1]), 1);
    step(1);
    check_output("follow_led_lo", 32'(gpio_led[1]), 0);
    check_output("led0_still_on", 32'(gpio_led[0]), 1);
    check_output("led3_still_off", 32'(gpio_led[3]), 0);

    // ---- 4: out-of-range index on the 3-LED build ----
    wr2 = 1'b1; idx2 = 2'd3; data2 = 2'b01;
    step(1);
    wr2 = 1'b0;
    step(1);
    check_output("oor_led", 32'(led2), 0);
    step(3);
    check_output("oor_led_later", 32'(led2), 0);
    wr2 = 1'b1; idx2 = 2'd2; data2 = 2'b01;
    step(1);
    wr2 = 1'b0;
    step(1);
    check_output("inrange_led", 32'(led2), 32'h4);

    // ---- 5: IRQ set/clear race ----
    clear_irq();
    check_output("race_irq_pre", 32'(sw_irq), 0);
    gpio_switch = 4'hC;
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      step(1);
      n++;
      if (sw_fall[0]) found = 1'b1;
    end
    check_output("race_fall_found", 32'(found), 1);
    check_output("race_irq_before", 32'(sw_irq), 0);
    clear_irq();
    check_output("race_irq_kept", 32'(sw_irq), 1);
    clear_irq();
    check_output("race_irq_cleared", 32'(sw_irq), 0);

    // ---- 6: async reset mid-debounce ----
    gpio_switch = 4'hF;
    step(7);
    #3 rst_n = 1'b0;
    #1;
    check_output("mid_rst_state", 32'(sw_state), 0);
    check_output("mid_rst_led", 32'(gpio_led), 0);
    check_output("mid_rst_edges", 32'({sw_rise, sw_fall}), 0);
    check_output("mid_rst_irq", 32'(sw_irq), 0);
    step(2);
    check_output("mid_rst_hold", 32'({gpio_led, sw_state, sw_rise, sw_fall, 3'b000, sw_irq}), 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      check_output("requal_wait", 32'({sw_state, sw_rise}), 0);
    end
    step(1);
    check_output("requal_state", 32'(sw_state), 32'hF);
    check_output("requal_rise", 32'(sw_rise), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
